// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_hazard_unit
// Purpose  : Forwarding and load-use hazard controller for a five-stage CPU.
//            Keeps a shadow copy of the destination-register information
//            for the instructions in EX, MEM and WB. From that copy it
//            drives the EX operand-mux selects. It also raises a one-cycle
//            stall whenever an instruction in ID needs the result of a load
//            that is currently in EX.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   REG_AW        register-address width
//   CNT_W         width of the saturating stall counter
// Ports
//   clk_i         clock; all state updates on the rising edge
//   rst_i         asynchronous active-low reset
//   id_valid_i    ID holds a real instruction
//   id_rs_i       rs of the ID instruction
//   id_rt_i       rt of the ID instruction
//   id_rd_i       final destination of the ID instruction (after RegDst)
//   id_regwrite_i ID instruction writes the register file
//   id_memread_i  ID instruction is a load
//   flush_i       taken branch/jump; the ID instruction is discarded
//   forward_a_o   operand-A select: 00 reg file, 01 WB data, 10 EX/MEM result
//   forward_b_o   operand-B select, same encoding
//   stall_o       load-use stall: hold PC and IF/ID, inject a bubble into EX
//   stall_cnt_o   saturating count of stall cycles
// ============================================================================
module forward_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0]        c_FWD_REG  = 2'b00;
  localparam logic [1:0]        c_FWD_WB   = 2'b01;
  localparam logic [1:0]        c_FWD_MEM  = 2'b10;
  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Stage records
  // --------------------------------------------------------------------------
  // EX record: this stage also keeps its source registers, because those
  // are the operands the forwarding muxes are choosing for.
  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_regwrite;
  logic              r_ex_memread;

  // MEM record
  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;
  logic              r_mem_memread;

  // WB record
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;
  logic              r_wb_memread;

  logic [CNT_W-1:0]  r_stall_cnt;

  // --------------------------------------------------------------------------
  // Combinational hazard / forwarding decode
  // --------------------------------------------------------------------------
  logic w_stall;
  logic w_ex_bubble;
  logic w_mem_live;
  logic w_wb_live;
  logic w_mem_hits_rs;
  logic w_mem_hits_rt;
  logic w_wb_hits_rs;
  logic w_wb_hits_rt;
  logic w_ex_load_live;

  // A stage can only forward when it is a real register-writing instruction
  // and its destination is not $0, which is hard-wired to zero.
  assign w_mem_live = r_mem_valid & r_mem_regwrite & (r_mem_rd != c_REG_ZERO);
  assign w_wb_live  = r_wb_valid  & r_wb_regwrite  & (r_wb_rd  != c_REG_ZERO);

  assign w_mem_hits_rs = w_mem_live & (r_mem_rd == r_ex_rs);
  assign w_mem_hits_rt = w_mem_live & (r_mem_rd == r_ex_rt);
  assign w_wb_hits_rs  = w_wb_live  & (r_wb_rd  == r_ex_rs);
  assign w_wb_hits_rt  = w_wb_live  & (r_wb_rd  == r_ex_rt);

  // MEM holds the younger result, so it takes priority over WB. The
  // encoding 11 is never produced.
  always_comb begin
    forward_a_o = c_FWD_REG;
    if (w_mem_hits_rs) begin
      forward_a_o = c_FWD_MEM;
    end else if (w_wb_hits_rs) begin
      forward_a_o = c_FWD_WB;
    end
  end

  always_comb begin
    forward_b_o = c_FWD_REG;
    if (w_mem_hits_rt) begin
      forward_b_o = c_FWD_MEM;
    end else if (w_wb_hits_rt) begin
      forward_b_o = c_FWD_WB;
    end
  end

  // Load in EX whose result is not yet available for forwarding. rt is
  // compared even for instructions that do not read it. That costs an
  // occasional extra stall but saves decode information here.
  assign w_ex_load_live = r_ex_valid & r_ex_memread & (r_ex_rd != c_REG_ZERO);

  // A flush discards the ID instruction, so a hazard against it is moot.
  assign w_stall = ~flush_i & id_valid_i & w_ex_load_live &
                   ((r_ex_rd == id_rs_i) | (r_ex_rd == id_rt_i));

  assign w_ex_bubble = flush_i | w_stall;

  // --------------------------------------------------------------------------
  // Pipeline shadow registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memread   <= 1'b0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memread   <= r_mem_memread;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
    end
  end

  // A bubble carries zeroed register fields so that no stale address can
  // ever match in the forwarding compare.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
    end else if (w_ex_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
    end else begin
      r_ex_valid     <= id_valid_i;
      r_ex_rd        <= id_rd_i;
      r_ex_rs        <= id_rs_i;
      r_ex_rt        <= id_rt_i;
      r_ex_regwrite  <= id_regwrite_i;
      r_ex_memread   <= id_memread_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stall cycle counter: saturates, cleared only by reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_forward_hazard_unit
// Purpose  : Self-checking bench for forward_hazard_unit. It runs directed
//            instruction sequences and then random traffic. Every cycle the
//            outputs are compared against a reference pipeline kept as an
//            array of instruction records.
// Revision : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;   // narrow so saturation is reached in the run
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              id_valid_i = 1'b0;
  logic [REG_AW-1:0] id_rs_i = '0;
  logic [REG_AW-1:0] id_rt_i = '0;
  logic [REG_AW-1:0] id_rd_i = '0;
  logic              id_regwrite_i = 1'b0;
  logic              id_memread_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [1:0]        forward_a_o;
  logic [1:0]        forward_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  forward_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rd_i      (id_rd_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .forward_a_o  (forward_a_o),
    .forward_b_o  (forward_b_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: one instruction record per stage, index 0=EX 1=MEM 2=WB.
  typedef struct {
    bit valid;
    int rs;
    int rt;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  instr_t pipe [3];
  int     m_cnt;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.ld = 0;
    return b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    m_cnt = 0;
  endfunction

  // Does the instruction produce a forwardable value for register r?
  function automatic bit produces(instr_t s, int r);
    return s.valid && s.rw && (s.rd != 0) && (s.rd == r);
  endfunction

  // Youngest producer wins: MEM (select 2), then WB (select 1), else 0.
  function automatic int exp_sel(int r);
    if (produces(pipe[1], r)) return 2;
    if (produces(pipe[2], r)) return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    instr_t e;
    e = pipe[0];
    if (flush_i || !id_valid_i) return 0;
    if (!(e.valid && e.ld && e.rd != 0)) return 0;
    return (e.rd == int'(id_rs_i)) || (e.rd == int'(id_rt_i));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string ctx);
    chk({ctx, ".fwd_a"}, int'(forward_a_o), exp_sel(pipe[0].rs));
    chk({ctx, ".fwd_b"}, int'(forward_b_o), exp_sel(pipe[0].rt));
    chk({ctx, ".stall"}, int'(stall_o),     int'(exp_stall()));
    chk({ctx, ".cnt"},   int'(stall_cnt_o), m_cnt);
  endtask

  // Drive ID fields (while clk is low) and check the settled outputs.
  task automatic apply(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit ld, input bit fl,
                       input string ctx);
    id_valid_i    = v;
    id_rs_i       = REG_AW'(rs);
    id_rt_i       = REG_AW'(rt);
    id_rd_i       = REG_AW'(rd);
    id_regwrite_i = rw;
    id_memread_i  = ld;
    flush_i       = fl;
    #1;
    chk_model(ctx);
  endtask

  task automatic idle(input string ctx);
    apply(0, 0, 0, 0, 0, 0, 0, ctx);
  endtask

  // One rising edge; the model advances using the inputs held across it.
  task automatic tick();
    instr_t nx;
    bit     st;
    st = exp_stall();
    nx.valid = id_valid_i; nx.rs = int'(id_rs_i); nx.rt = int'(id_rt_i);
    nx.rd = int'(id_rd_i); nx.rw = id_regwrite_i; nx.ld = id_memread_i;
    @(posedge clk_i);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (flush_i || st) ? bubble() : nx;
    if (st && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk_i);
  endtask

  initial begin
    bit hold;
    model_reset();

    // Reset held, idle inputs
    @(negedge clk_i);
    #1;
    chk("rst.fwd_a", int'(forward_a_o), 0);
    chk("rst.stall", int'(stall_o), 0);
    chk("rst.cnt",   int'(stall_cnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle("idle0"); tick();
    idle("idle1"); tick();

    // add $3 <- $1,$2 ; sub $4 <- $3,$5
    apply(1, 1, 2, 3, 1, 0, 0, "add");  tick();
    apply(1, 3, 5, 4, 1, 0, 0, "sub");  tick();
    idle("sub_ex");
    chk("sub_ex.fa_mem", int'(forward_a_o), 2);
    chk("sub_ex.fb_reg", int'(forward_b_o), 0);
    tick(); idle("d1"); tick(); idle("d2"); tick();

    // add $3 ; nop ; or $6 <- $7,$3
    apply(1, 1, 2, 3, 1, 0, 0, "add2"); tick();
    idle("nop");                        tick();
    apply(1, 7, 3, 6, 1, 0, 0, "or");   tick();
    idle("or_ex");
    chk("or_ex.fb_wb",  int'(forward_b_o), 1);
    chk("or_ex.fa_reg", int'(forward_a_o), 0);
    tick(); idle("d3"); tick(); idle("d4"); tick();

    // add $3 ; add $3 ; and $8 <- $3,$3
    apply(1, 1, 2, 3, 1, 0, 0, "addA"); tick();
    apply(1, 4, 5, 3, 1, 0, 0, "addB"); tick();
    apply(1, 3, 3, 8, 1, 0, 0, "and");  tick();
    idle("and_ex");
    chk("and_ex.fa_mem", int'(forward_a_o), 2);
    chk("and_ex.fb_mem", int'(forward_b_o), 2);
    tick(); idle("d5"); tick(); idle("d6"); tick();

    // lw $2 ; add $5 <- $2,$2
    apply(1, 1, 0, 2, 1, 1, 0, "lw");   tick();
    apply(1, 2, 2, 5, 1, 0, 0, "use");
    chk("lu.stall1", int'(stall_o), 1);
    chk("lu.cnt0",   int'(stall_cnt_o), 0);
    tick();
    apply(1, 2, 2, 5, 1, 0, 0, "use_hold");
    chk("lu.stall0", int'(stall_o), 0);
    chk("lu.cnt1",   int'(stall_cnt_o), 1);
    tick();
    idle("use_ex");
    chk("lu.fa_wb", int'(forward_a_o), 1);
    chk("lu.fb_wb", int'(forward_b_o), 1);
    tick(); idle("d7"); tick(); idle("d8"); tick();

    // Write $0 then read $0: never forwarded
    apply(1, 1, 2, 0, 1, 0, 0, "wr0");  tick();
    apply(1, 0, 0, 9, 1, 0, 0, "rd0");  tick();
    idle("rd0_ex");
    chk("r0.fa", int'(forward_a_o), 0);
    chk("r0.fb", int'(forward_b_o), 0);
    tick(); idle("d9"); tick(); idle("d10"); tick();

    // Hazard with flush: flush wins, count unchanged
    apply(1, 1, 0, 2, 1, 1, 0, "lw_f"); tick();
    apply(1, 2, 6, 7, 1, 0, 1, "flush");
    chk("fl.stall", int'(stall_o), 0);
    tick();
    idle("after_fl");
    chk("fl.cnt", int'(stall_cnt_o), 1);
    tick(); idle("d11"); tick(); idle("d12"); tick();

    // Reset asserted mid-stall, no clock edge needed
    apply(1, 1, 0, 4, 1, 1, 0, "lw_r"); tick();
    apply(1, 4, 1, 5, 1, 0, 0, "stall_r");
    chk("pre_rst.stall", int'(stall_o), 1);
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("async_rst.stall", int'(stall_o), 0);
    chk("async_rst.cnt",   int'(stall_cnt_o), 0);
    chk("async_rst.fa",    int'(forward_a_o), 0);
    chk("async_rst.fb",    int'(forward_b_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Random traffic over a small register window to provoke hazards.
    // A stalled ID instruction is held, as the real IF/ID register would.
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold) begin
        apply(id_valid_i, int'(id_rs_i), int'(id_rt_i), int'(id_rd_i),
              id_regwrite_i, id_memread_i, ($urandom_range(0, 15) == 0), "rnd");
      end else begin
        bit rw;
        rw = ($urandom_range(0, 9) < 7);
        apply(($urandom_range(0, 9) < 9),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), rw,
              rw && ($urandom_range(0, 9) < 4),
              ($urandom_range(0, 15) == 0), "rnd");
      end
      hold = stall_o;
      tick();
    end
    idle("final");
    chk("sat.cnt", int'(stall_cnt_o), CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
